// File: rtl/big_number_sorter.sv
// Descending batch sorter: loads DEPTH bytes, bubble-sorts them in place through a
// single compare-swap stage on a fixed schedule, then drains them largest-first.

module big_number_first (
  input  logic [7:0] aIn,
  input  logic [7:0] bIn,
  output logic [7:0] aOut,
  output logic [7:0] bOut
);
  // Swap only on strictly greater so equal pairs pass through unchanged.
  logic w_swap;
  assign w_swap = (bIn > aIn);
  assign aOut   = w_swap ? bIn : aIn;
  assign bOut   = w_swap ? aIn : bIn;
endmodule

module big_number_sorter #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy
);
  localparam int CW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST     = CW'(DEPTH - 1);
  localparam logic [CW-1:0] IDX_LAST = CW'(DEPTH - 2);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SORT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [DEPTH-1:0][7:0] r_slot;
  logic [CW-1:0]         r_load_cnt;
  logic [CW-1:0]         r_idx;
  logic [CW-1:0]         r_pass;
  logic [CW-1:0]         r_out_cnt;

  logic [CW-1:0] w_idx1;
  logic [7:0]    w_a_in, w_b_in, w_a_out, w_b_out;

  assign w_idx1 = r_idx + 1'b1;
  assign w_a_in = r_slot[r_idx];
  assign w_b_in = r_slot[w_idx1];

  big_number_first u_cmp (
    .aIn  (w_a_in),
    .bIn  (w_b_in),
    .aOut (w_a_out),
    .bOut (w_b_out)
  );

  // Handshake-facing outputs depend on registers only.
  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = (r_state == S_DRAIN);
  assign busy      = (r_state == S_SORT) || (r_state == S_DRAIN);
  assign out_last  = (r_state == S_DRAIN) && (r_out_cnt == LAST);
  assign out_data  = (r_state == S_DRAIN) ? r_slot[r_out_cnt] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_LOAD;
      r_slot     <= '0;
      r_load_cnt <= '0;
      r_idx      <= '0;
      r_pass     <= '0;
      r_out_cnt  <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            r_slot[r_load_cnt] <= in_data;
            if (r_load_cnt == LAST) begin
              r_load_cnt <= '0;
              r_state    <= S_SORT;
            end else begin
              r_load_cnt <= r_load_cnt + 1'b1;
            end
          end
        end
        S_SORT: begin
          r_slot[r_idx]  <= w_a_out;
          r_slot[w_idx1] <= w_b_out;
          if (r_idx == IDX_LAST) begin
            r_idx <= '0;
            if (r_pass == IDX_LAST) begin
              r_pass  <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_pass <= r_pass + 1'b1;
            end
          end else begin
            r_idx <= w_idx1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (r_out_cnt == LAST) begin
              r_out_cnt <= '0;
              r_state   <= S_LOAD;
            end else begin
              r_out_cnt <= r_out_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_big_number_sorter.sv
// Self-checking bench for big_number_sorter (DEPTH=4) against a sorted-copy reference.

module tb_big_number_sorter;
  typedef logic [7:0] vec_t [4];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int errors = 0;
  int checks = 0;
  bit keep_ready = 1'b0;

  big_number_sorter #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: the expected drain order is the batch sorted largest-first.
  function automatic vec_t ref_sort(input vec_t v);
    vec_t r;
    logic [7:0] t;
    r = v;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (r[j] > r[i]) begin t = r[i]; r[i] = r[j]; r[j] = t; end
    return r;
  endfunction

  task automatic push(input logic [7:0] v);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 4; i++) push(v[i]);
  endtask

  // mode 0: no stalls, 1: 3-cycle stall after first value, 2: random stalls
  task automatic drain(input string nm, input vec_t exp, input int mode);
    int stalls;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 60) begin @(negedge clk); n++; end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s_valid_timeout[%0d]: out_valid=%0b required 1", nm, i, out_valid);
        return;
      end
      checks++;
      if (out_data !== exp[i]) begin
        errors++;
        $display("FAIL %s_data[%0d]: got %h expected %h", nm, i, out_data, exp[i]);
      end
      checks++;
      if (out_last !== (i == 3)) begin
        errors++;
        $display("FAIL %s_last[%0d]: got %0b expected %0b", nm, i, out_last, (i == 3));
      end
      stalls = (mode == 1 && i == 0) ? 3 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      if (!keep_ready) begin
        out_ready = 1'b0;
        repeat (stalls) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 3)) begin
            errors++;
            $display("FAIL %s_hold[%0d]: valid=%0b data=%h last=%0b expected valid=1 data=%h",
                     nm, i, out_valid, out_data, out_last, exp[i]);
          end
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      if (!keep_ready) out_ready = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_last: in_ready=%0b out_valid=%0b busy=%0b expected 1/0/0",
               nm, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 ||
        out_last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%0b out_valid=%0b out_data=%h out_last=%0b busy=%0b expected 1/0/00/0/0",
               in_ready, out_valid, out_data, out_last, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_sort();
    vec_t a = '{8'd40, 8'd10, 8'd90, 8'd20};
    vec_t b = '{8'd5, 8'd9, 8'd1, 8'd7};
    vec_t e = '{8'd9, 8'd7, 8'd5, 8'd1};
    load(a);
    @(posedge clk); @(posedge clk); #2;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midsort_busy: busy=%0b in_ready=%0b expected 1/0", busy, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL midsort_reset: in_ready=%0b out_valid=%0b busy=%0b out_data=%h expected 1/0/0/00",
               in_ready, out_valid, busy, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load(b);
    drain("after_reset", e, 0);
  endtask

  task automatic test_mixed_latency();
    vec_t v = '{8'h1C, 8'hFA, 8'hFC, 8'h1C};
    vec_t e = '{8'hFC, 8'hFA, 8'h1C, 8'h1C};
    int cnt = 0;
    load(v);
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL sort_flags: busy=%0b in_ready=%0b out_valid=%0b expected 1/0/0",
                   busy, in_ready, out_valid);
        end
      end
    end while (!out_valid && cnt < 40);
    checks++;
    if (cnt - 1 != 9) begin
      errors++;
      $display("FAIL sort_latency: got %0d cycles expected 9", cnt - 1);
    end
    drain("mixed", e, 0);
  endtask

  task automatic test_presorted();
    vec_t v [4];
    v[0] = '{8'd200, 8'd100, 8'd50, 8'd0};
    v[1] = '{8'd1, 8'd2, 8'd3, 8'd4};
    v[2] = '{8'h00, 8'h00, 8'h00, 8'h00};
    v[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    for (int k = 0; k < 4; k++) begin
      load(v[k]);
      drain($sformatf("presorted%0d", k), ref_sort(v[k]), 0);
    end
  endtask

  task automatic test_backpressure();
    vec_t v = '{8'd17, 8'd250, 8'd3, 8'd99};
    load(v);
    drain("backpressure", ref_sort(v), 1);
  endtask

  task automatic test_input_gaps();
    bit   pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vec_t cap;
    int   k = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = pat[i];
      in_data  = 8'($urandom_range(0, 255));
      if (pat[i]) begin cap[k] = in_data; k++; end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL gaps_count: busy=%0b in_ready=%0b expected 1/0 after 4 captures", busy, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL illegal_in_ready[%0d]: got %0b expected 0", i, in_ready);
      end
    end
    drain("gaps_aa", ref_sort(cap), 0);
  endtask

  task automatic test_back_to_back();
    vec_t a  = '{8'd3, 8'd1, 8'd2, 8'd0};
    vec_t b  = '{8'd8, 8'd8, 8'd9, 8'd7};
    vec_t ea = '{8'd3, 8'd2, 8'd1, 8'd0};
    vec_t eb = '{8'd9, 8'd8, 8'd8, 8'd7};
    keep_ready = 1'b1;
    out_ready  = 1'b1;
    load(a);
    drain("b2b_a", ea, 0);
    load(b);
    drain("b2b_b", eb, 0);
    keep_ready = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic test_random();
    vec_t v;
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < 4; i++)
        v[i] = 8'($urandom_range(0, (b % 2) ? 3 : 255));
      load(v);
      drain($sformatf("random%0d", b), ref_sort(v), 2);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_sort();
    test_mixed_latency();
    test_presorted();
    test_backpressure();
    test_input_gaps();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
